change_dispenser: RTL

Consumer side of the vending controller's change output. Accepts an 8-bit change amount with a valid strobe and pays it out as a sequence of single-coin requests to the coin-hopper mechanism. Uses a greedy largest-denomination-first algorithm. Each coin request waits for a hopper acknowledge, with a timeout fault.

---
 rtl/change_dispenser.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Pays out an 8-bit change amount as single-coin hopper requests.
// Denominations are chosen greedily, largest first, and each request has an acknowledge timeout.
module change_dispenser #(
  parameter int DEN0        = 20,
  parameter int DEN1        = 10,
  parameter int DEN2        = 5,
  parameter int DEN3        = 1,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       change_valid,
  input  logic [7:0] change,
  input  logic       coin_ack,
  output logic       busy,
  output logic       coin_valid,
  output logic [1:0] coin_denom,
  output logic [7:0] coin_count,
  output logic       done,
  output logic       fault
);

  localparam logic [7:0] D0 = 8'(DEN0);
  localparam logic [7:0] D1 = 8'(DEN1);
  localparam logic [7:0] D2 = 8'(DEN2);
  localparam logic [7:0] D3 = 8'(DEN3);
  localparam int         TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ISSUE,
    DONE,
    FAULT
  } state_t;

  state_t        state;
  logic [7:0]    remaining;
  logic [7:0]    cur_value;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic [1:0]    sel_code;
  logic [7:0]    sel_value;

  // Largest denomination that still fits in the remaining amount.
  always_comb begin
    sel_code  = 2'd3;
    sel_value = D3;
    if (remaining >= D0) begin
      sel_code  = 2'd0;
      sel_value = D0;
    end else if (remaining >= D1) begin
      sel_code  = 2'd1;
      sel_value = D1;
    end else if (remaining >= D2) begin
      sel_code  = 2'd2;
      sel_value = D2;
    end
  end

  assign timer_next = timer + TW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      cur_value  <= '0;
      timer      <= '0;
      busy       <= 1'b0;
      coin_valid <= 1'b0;
      coin_denom <= '0;
      coin_count <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy       <= 1'b0;
          coin_valid <= 1'b0;
          if (change_valid) begin
            remaining  <= change;
            coin_count <= '0;
            busy       <= 1'b1;
            state      <= SELECT;
          end
        end

        SELECT: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            coin_denom <= sel_code;
            cur_value  <= sel_value;
            coin_valid <= 1'b1;
            timer      <= '0;
            state      <= ISSUE;
          end
        end

        // An acknowledge on the same edge the timeout would expire still wins.
        ISSUE: begin
          if (coin_ack) begin
            remaining  <= remaining - cur_value;
            coin_count <= coin_count + 8'd1;
            coin_valid <= 1'b0;
            state      <= SELECT;
          end else if (timer_next == TW'(ACK_TIMEOUT)) begin
            timer      <= timer_next;
            coin_valid <= 1'b0;
            fault      <= 1'b1;
            state      <= FAULT;
          end else begin
            timer <= timer_next;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        FAULT: begin
          busy       <= 1'b1;
          coin_valid <= 1'b0;
          fault      <= 1'b1;
        end

        default: begin
          busy       <= 1'b0;
          coin_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
